// File: rtl/fifo_scatter_pkg.sv
// fifo_scatter_pkg: shared channel encodings and width helper for the scatter block.
package fifo_scatter_pkg;

   localparam logic [1:0] CH_A       = 2'd0;
   localparam logic [1:0] CH_B       = 2'd1;
   localparam logic [1:0] CH_C       = 2'd2;
   localparam logic [1:0] CH_ILLEGAL = 2'd3;

   // Ceiling log2 for elaboration-time width derivation.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage : fifo_scatter_pkg

// File: rtl/fifo_scatter_if.sv
// fifo_scatter_if: tagged input stream plus three per-channel valid/ready output ports.
interface fifo_scatter_if
   import fifo_scatter_pkg::*;
#(
   parameter int unsigned W_DATA = 16,
   parameter int unsigned DEPTH  = 8
);
   localparam int unsigned W_CNT = clog2(DEPTH) + 1;

   logic [W_DATA-1:0] din;
   logic [1:0]        din_channel;
   logic              din_vld;
   logic              din_rdy;

   logic [W_DATA-1:0] dout_a, dout_b, dout_c;
   logic              dout_a_vld, dout_b_vld, dout_c_vld;
   logic              dout_a_rdy, dout_b_rdy, dout_c_rdy;
   logic [W_CNT-1:0]  cnt_a, cnt_b, cnt_c;
   logic              err;

   // Upstream producer / downstream consumers.
   modport master (
      output din, din_channel, din_vld,
      output dout_a_rdy, dout_b_rdy, dout_c_rdy,
      input  din_rdy,
      input  dout_a, dout_b, dout_c,
      input  dout_a_vld, dout_b_vld, dout_c_vld,
      input  cnt_a, cnt_b, cnt_c, err
   );

   // The scatter block itself.
   modport slave (
      input  din, din_channel, din_vld,
      input  dout_a_rdy, dout_b_rdy, dout_c_rdy,
      output din_rdy,
      output dout_a, dout_b, dout_c,
      output dout_a_vld, dout_b_vld, dout_c_vld,
      output cnt_a, cnt_b, cnt_c, err
   );

endinterface : fifo_scatter_if

// File: rtl/fifo_scatter_sync_fwft_fifo.sv
// sync_fwft_fifo: single-clock first-word-fall-through FIFO; head word is zero when empty.
module sync_fwft_fifo
   import fifo_scatter_pkg::*;
#(
   parameter int unsigned W_DATA = 16,
   parameter int unsigned DEPTH  = 8
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [W_DATA-1:0]           din,
   input  logic                        rd_en,
   output logic [W_DATA-1:0]           dout,
   output logic                        empty,
   output logic                        full,
   output logic [clog2(DEPTH):0]       cnt
);
   localparam int unsigned W_PTR = clog2(DEPTH);
   localparam int unsigned W_CNT = W_PTR + 1;

   logic [W_DATA-1:0] r_mem [DEPTH];
   logic [W_PTR-1:0]  r_wr_ptr;
   logic [W_PTR-1:0]  r_rd_ptr;
   logic [W_CNT-1:0]  r_cnt;
   logic              w_push;
   logic              w_pop;

   // Full is judged on the pre-pop count, so a push alongside a pop on a full FIFO is refused.
   assign full   = (r_cnt == W_CNT'(DEPTH));
   assign empty  = (r_cnt == '0);
   assign w_push = wr_en && !full;
   assign w_pop  = rd_en && !empty;
   assign cnt    = r_cnt;
   assign dout   = empty ? '0 : r_mem[r_rd_ptr];

   // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + W_PTR'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + W_PTR'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + W_CNT'(1);
            2'b01:   r_cnt <= r_cnt - W_CNT'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule : sync_fwft_fifo

// File: rtl/fifo_scatter.sv
// fifo_scatter: steers a tagged stream into three independent FWFT channel FIFOs.
// Build option: FIFO_SCATTER_STICKY_ERR_EN makes err sticky until reset instead of a per-drop pulse.
module fifo_scatter
   import fifo_scatter_pkg::*;
#(
   parameter int unsigned W_DATA = 16,
   parameter int unsigned DEPTH  = 8
)(
   input  logic           clk,
   input  logic           rst_n,
   fifo_scatter_if.slave  bus
);
   localparam int unsigned W_CNT = clog2(DEPTH) + 1;

   logic             w_full_a, w_full_b, w_full_c;
   logic             w_empty_a, w_empty_b, w_empty_c;
   logic [W_CNT-1:0] w_cnt_a, w_cnt_b, w_cnt_c;
   logic             w_tgt_full;
   logic             w_legal;
   logic             w_din_rdy;
   logic             w_drop;
   logic             r_err;

   // Select the full flag of the addressed channel; the illegal code reads as blocked.
   always_comb begin
      w_tgt_full = 1'b1;
      w_legal    = 1'b0;
      case (bus.din_channel)
         CH_A:    begin w_tgt_full = w_full_a; w_legal = 1'b1; end
         CH_B:    begin w_tgt_full = w_full_b; w_legal = 1'b1; end
         CH_C:    begin w_tgt_full = w_full_c; w_legal = 1'b1; end
         default: begin w_tgt_full = 1'b1;     w_legal = 1'b0; end
      endcase
   end

   assign w_din_rdy   = w_legal && !w_tgt_full;
   assign w_drop      = bus.din_vld && !w_din_rdy;
   assign bus.din_rdy = w_din_rdy;

   // Drop indication, registered one cycle after the offending word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
`ifdef FIFO_SCATTER_STICKY_ERR_EN
         r_err <= r_err || w_drop;
`else
         r_err <= w_drop;
`endif
      end
   end

   assign bus.err = r_err;

   sync_fwft_fifo #(.W_DATA(W_DATA), .DEPTH(DEPTH)) u_fifo_a (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (bus.din_vld && w_din_rdy && (bus.din_channel == CH_A)),
      .din   (bus.din),
      .rd_en (bus.dout_a_rdy),
      .dout  (bus.dout_a),
      .empty (w_empty_a),
      .full  (w_full_a),
      .cnt   (w_cnt_a)
   );

   sync_fwft_fifo #(.W_DATA(W_DATA), .DEPTH(DEPTH)) u_fifo_b (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (bus.din_vld && w_din_rdy && (bus.din_channel == CH_B)),
      .din   (bus.din),
      .rd_en (bus.dout_b_rdy),
      .dout  (bus.dout_b),
      .empty (w_empty_b),
      .full  (w_full_b),
      .cnt   (w_cnt_b)
   );

   sync_fwft_fifo #(.W_DATA(W_DATA), .DEPTH(DEPTH)) u_fifo_c (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (bus.din_vld && w_din_rdy && (bus.din_channel == CH_C)),
      .din   (bus.din),
      .rd_en (bus.dout_c_rdy),
      .dout  (bus.dout_c),
      .empty (w_empty_c),
      .full  (w_full_c),
      .cnt   (w_cnt_c)
   );

   assign bus.dout_a_vld = !w_empty_a;
   assign bus.dout_b_vld = !w_empty_b;
   assign bus.dout_c_vld = !w_empty_c;
   assign bus.cnt_a      = w_cnt_a;
   assign bus.cnt_b      = w_cnt_b;
   assign bus.cnt_c      = w_cnt_c;

endmodule : fifo_scatter

// File: tb/tb_fifo_scatter.sv
// tb_fifo_scatter: directed checks of routing, full/drop, illegal channel, wrap-around and async reset.
module tb_fifo_scatter;
   localparam int unsigned W_DATA = 16;
   localparam int unsigned DEPTH  = 8;

`ifdef FIFO_SCATTER_STICKY_ERR_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_run;
   int   n_fail;

   fifo_scatter_if #(.W_DATA(W_DATA), .DEPTH(DEPTH)) bus ();

   fifo_scatter #(.W_DATA(W_DATA), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [15:0] q[$];
   int          mc;
   int          widx;
   int          cyc;
   logic        do_push;
   logic        do_pop;

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.din         = '0;
      bus.din_channel = 2'd0;
      bus.din_vld     = 1'b0;
      bus.dout_a_rdy  = 1'b0;
      bus.dout_b_rdy  = 1'b0;
      bus.dout_c_rdy  = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_cnt_a", 32'(bus.cnt_a), 32'd0);
      chk("rst_cnt_b", 32'(bus.cnt_b), 32'd0);
      chk("rst_cnt_c", 32'(bus.cnt_c), 32'd0);
      chk("rst_vlds", 32'({bus.dout_a_vld, bus.dout_b_vld, bus.dout_c_vld}), 32'd0);
      chk("rst_douts", 32'(bus.dout_a | bus.dout_b | bus.dout_c), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;
      tick();

      // One word to each channel, consumers always ready
      bus.dout_a_rdy = 1'b1; bus.dout_b_rdy = 1'b1; bus.dout_c_rdy = 1'b1;
      bus.din = 16'h1111; bus.din_channel = 2'd0; bus.din_vld = 1'b1;
      #1 chk("t1_din_rdy", 32'(bus.din_rdy), 32'd1);
      tick();
      chk("t1_dout_a", 32'(bus.dout_a), 32'h1111);
      chk("t1_vld_a", 32'(bus.dout_a_vld), 32'd1);
      chk("t1_cnt_a", 32'(bus.cnt_a), 32'd1);
      bus.din = 16'h2222; bus.din_channel = 2'd1;
      tick();
      chk("t1_vld_a_gone", 32'(bus.dout_a_vld), 32'd0);
      chk("t1_dout_a_zero", 32'(bus.dout_a), 32'd0);
      chk("t1_dout_b", 32'(bus.dout_b), 32'h2222);
      chk("t1_vld_b", 32'(bus.dout_b_vld), 32'd1);
      bus.din = 16'h3333; bus.din_channel = 2'd2;
      tick();
      chk("t1_vld_b_gone", 32'(bus.dout_b_vld), 32'd0);
      chk("t1_dout_c", 32'(bus.dout_c), 32'h3333);
      chk("t1_vld_c", 32'(bus.dout_c_vld), 32'd1);
      bus.din_vld = 1'b0;
      tick();
      chk("t1_vld_c_gone", 32'(bus.dout_c_vld), 32'd0);
      chk("t1_err", 32'(bus.err), 32'd0);

      // Fill channel A with its consumer stalled, then overflow
      bus.dout_a_rdy = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         bus.din = 16'(i); bus.din_channel = 2'd0; bus.din_vld = 1'b1;
         tick();
      end
      chk("t2_cnt_full", 32'(bus.cnt_a), 32'd8);
      chk("t2_head", 32'(bus.dout_a), 32'h0001);
      chk("t2_err_before", 32'(bus.err), 32'd0);
      bus.din = 16'h0009;
      #1 chk("t2_din_rdy_full", 32'(bus.din_rdy), 32'd0);
      tick();
      chk("t2_err_drop", 32'(bus.err), 32'd1);
      chk("t2_cnt_hold", 32'(bus.cnt_a), 32'd8);

      // Push and pop together on a full FIFO: pop wins, push dropped
      bus.din = 16'hAAAA; bus.dout_a_rdy = 1'b1;
      #1 chk("t3_din_rdy", 32'(bus.din_rdy), 32'd0);
      chk("t3_head", 32'(bus.dout_a), 32'h0001);
      tick();
      chk("t3_cnt_7", 32'(bus.cnt_a), 32'd7);
      chk("t3_err", 32'(bus.err), 32'd1);
      bus.din_vld = 1'b0;
      for (int i = 2; i <= 8; i++) begin
         chk("t3_drain", 32'(bus.dout_a), 32'(i));
         tick();
      end
      chk("t3_err_after", 32'(bus.err), 32'(STICKY));
      chk("t3_vld_a_empty", 32'(bus.dout_a_vld), 32'd0);
      chk("t3_cnt_a_empty", 32'(bus.cnt_a), 32'd0);
      chk("t3_dout_a_empty", 32'(bus.dout_a), 32'd0);

      // Illegal channel
      bus.din = 16'hBEEF; bus.din_channel = 2'd3; bus.din_vld = 1'b1;
      #1 chk("t4_din_rdy", 32'(bus.din_rdy), 32'd0);
      tick();
      bus.din_vld = 1'b0;
      chk("t4_err", 32'(bus.err), 32'd1);
      chk("t4_cnts", 32'({bus.cnt_a, bus.cnt_b, bus.cnt_c}), 32'd0);
      chk("t4_vlds", 32'({bus.dout_a_vld, bus.dout_b_vld, bus.dout_c_vld}), 32'd0);
      tick();
      chk("t4_err_after", 32'(bus.err), 32'(STICKY));

      // Channel B stream with toggling ready: order, bound and wrap-around
      q.delete();
      mc   = 0;
      widx = 0;
      cyc  = 0;
      while ((widx < 20 || mc > 0) && cyc < 200) begin
         bus.din         = 16'hB000 + 16'(widx);
         bus.din_channel = 2'd1;
         bus.din_vld     = (widx < 20) && ((cyc % 3) != 2);
         bus.dout_b_rdy  = ((cyc % 2) == 1);
         #1;
         chk("t5_cnt_b", 32'(bus.cnt_b), 32'(mc));
         chk("t5_vld_b", 32'(bus.dout_b_vld), 32'(mc > 0));
         if (bus.din_vld) chk("t5_din_rdy", 32'(bus.din_rdy), 32'(mc < 8));
         do_pop  = (mc > 0) && bus.dout_b_rdy;
         do_push = bus.din_vld && (mc < 8);
         if (do_pop) begin
            chk("t5_order", 32'(bus.dout_b), 32'(q[0]));
            void'(q.pop_front());
         end
         if (do_push) begin
            q.push_back(bus.din);
            widx++;
         end
         mc = mc + int'(do_push) - int'(do_pop);
         tick();
         cyc++;
      end
      bus.din_vld = 1'b0;
      chk("t5_completed", 32'(cyc < 200), 32'd1);
      chk("t5_all_pushed", 32'(widx), 32'd20);
      chk("t5_cnt_b_end", 32'(bus.cnt_b), 32'd0);

      // Asynchronous reset with channel C partly filled
      bus.dout_c_rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         bus.din = 16'hC000 + 16'(i); bus.din_channel = 2'd2; bus.din_vld = 1'b1;
         tick();
      end
      bus.din_vld = 1'b0;
      chk("t6_cnt_c", 32'(bus.cnt_c), 32'd5);
      chk("t6_head_c", 32'(bus.dout_c), 32'hC001);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_cnt_c", 32'(bus.cnt_c), 32'd0);
      chk("t6_rst_vld_c", 32'(bus.dout_c_vld), 32'd0);
      chk("t6_rst_dout_c", 32'(bus.dout_c), 32'd0);
      chk("t6_rst_err", 32'(bus.err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.din = 16'h7777; bus.din_channel = 2'd2; bus.din_vld = 1'b1;
      tick();
      bus.din_vld = 1'b0;
      chk("t6_first_after_rst", 32'(bus.dout_c), 32'h7777);
      chk("t6_cnt_after_rst", 32'(bus.cnt_c), 32'd1);
      bus.dout_c_rdy = 1'b1;
      tick();
      chk("t6_drained", 32'(bus.dout_c_vld), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule : tb_fifo_scatter

// File: doc/fifo_scatter.md
Name: fifo_scatter

Overview:
- Single-clock distributor; the counterpart of the three-channel FIFO gather.
- Accepts one tagged input stream (data plus 2-bit channel). Steers each word into one of three per-channel synchronous FIFOs, A, B or C.
- Each channel drains on its own valid/ready output port.
- Sits downstream of a gather/transport link and restores the three original streams.

Parameters:
- W_DATA, 16, data width of input and all channel outputs.
- DEPTH, 8, words per channel FIFO; power of two, at least 2.
- W_CNT, log2(DEPTH)+1, derived occupancy width; localparam, not overridable.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  W_DATA  tagged input data.
- din_channel  input  2  destination: 0=A, 1=B, 2=C; 3 is illegal.
- din_vld  input  1  din/din_channel valid this cycle.
- din_rdy  output  1  combinational; high when din_channel is legal and that FIFO is not full.
- dout_a / dout_b / dout_c  output  W_DATA  head word of each channel FIFO.
- dout_a_vld / dout_b_vld / dout_c_vld  output  1  channel FIFO not empty.
- dout_a_rdy / dout_b_rdy / dout_c_rdy  input  1  downstream accepts head word.
- cnt_a / cnt_b / cnt_c  output  W_CNT  current occupancy of each FIFO.
- err  output  1  overflow or illegal-channel indication.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low.
  - All state is cleared on rst_n low.
- Reset values:
  - All FIFOs empty; all pointers and counts 0.
  - dout_x = 0; dout_x_vld = 0; err = 0.
- Push:
  - Push to channel k when din_vld && din_rdy && din_channel==k.
  - The word is written at that clock edge.
- Drop conditions (word discarded, no FIFO state changes):
  - din_vld with din_channel==3.
  - din_vld with the target FIFO full.
  - In both cases err asserts on the following cycle.
- Pop:
  - Pop channel k when dout_k_vld && dout_k_rdy.
  - Pop is first-word-fall-through: dout_k presents the head word whenever dout_k_vld=1.
- Latency:
  - A word pushed at edge N appears on dout_k with dout_k_vld=1 after edge N (one cycle) when the FIFO was empty.
  - dout_k holds its value while vld && !rdy.
- Empty FIFO:
  - dout_k_vld=0 and dout_k=0.
  - dout_k_rdy is ignored.
- Full FIFO:
  - cnt_k==DEPTH; din_rdy=0 for that channel.
  - A push in the same cycle as a pop on a full FIFO is rejected; full is evaluated before the pop.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both occur.
- Push into an empty FIFO: visible next cycle only; no combinational bypass from din to dout.
- Pointers:
  - W_CNT-1 bits, wrap modulo DEPTH.
  - Count updates: +1 on push only, -1 on pop only, unchanged otherwise.
- Independence: the three channels are fully independent; backpressure on one never stalls pushes to another.
- Reset mid-operation: contents discarded immediately; outputs return to reset values asynchronously.

Optional Feature:
- Macro: FIFO_SCATTER_STICKY_ERR_EN.
- Defined: err is sticky; it sets on the first drop and holds until rst_n is low.
- Undefined: err is a one-cycle pulse per dropped word, registered the cycle after the drop.

Decomposition:
- Shared package fifo_scatter_pkg holds:
  - channel encoding constants CH_A=0, CH_B=1, CH_C=2, CH_ILLEGAL=3;
  - function clog2 used for W_CNT.
- Natural sub-module: sync_fwft_fifo (W_DATA, DEPTH; wr_en, rd_en, dout, empty, full, cnt), instantiated three times.
- Top level holds only the channel decode, din_rdy mux and err logic.

Test Plan:
- Reset, then push 0x1111 to ch0, 0x2222 to ch1, 0x3333 to ch2 on consecutive cycles with all dout_rdy=1 -> each dout_x_vld pulses one cycle with the matching word; err stays 0.
- Hold dout_a_rdy=0, push 9 words 0x0001..0x0009 to ch0 -> cnt_a reaches 8 and din_rdy drops. Word 0x0009 is dropped and err asserts. Releasing rdy then drains 0x0001..0x0008 in order.
- With ch0 full, assert din_vld (0xAAAA, ch0) and dout_a_rdy=1 in the same cycle -> pop occurs, push rejected, cnt_a=7, err=1 next cycle.
- Push 0xBEEF with din_channel=3 -> no FIFO changes, all cnt unchanged, err=1 (pulse, or sticky under FIFO_SCATTER_STICKY_ERR_EN).
- Interleave pushes to ch1 with dout_b_rdy toggling every cycle for 20 words -> output order identical to input, cnt_b never exceeds 8, wrap-around verified.
- Assert rst_n=0 mid-stream with ch2 holding 5 words -> cnt_c=0 and dout_c_vld=0 immediately; the next push after release emerges first.
